// File: rtl/synth_env_pkg.sv
// Shared constants for the per-voice envelope: widths, unity gain and the
// envelope FSM state encodings.
package synth_env_pkg;

  localparam int LVL_W       = 31;
  localparam int WAVE_W      = 32;
  localparam int UNITY_SHIFT = 30;

  // Unity gain level; also the default peak amplitude.
  localparam logic [LVL_W-1:0] UNITY = 31'(64'd1 << UNITY_SHIFT);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

endpackage

// File: rtl/adsr_envelope_ctrl_env_scaler.sv
// env_scaler: multiplies a signed sample by the unsigned envelope level,
// drops the unity-gain fraction bits and saturates to the sample width.
// Output register updates only on the sample tick.
module env_scaler #(
  parameter int LVL_W       = synth_env_pkg::LVL_W,
  parameter int WAVE_W      = synth_env_pkg::WAVE_W,
  parameter int UNITY_SHIFT = synth_env_pkg::UNITY_SHIFT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic signed [WAVE_W-1:0] wave_in,
  input  logic        [LVL_W-1:0]  level,
  output logic signed [WAVE_W-1:0] wave_out,
  output logic                     wave_valid
);

  localparam int PROD_W = WAVE_W + LVL_W;

  logic signed [PROD_W-1:0] wave_ext;
  logic signed [PROD_W-1:0] level_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;

  // Clamp to the sample range when the upper bits are not a pure sign extension.
  function automatic logic signed [WAVE_W-1:0] sat_wave(input logic signed [PROD_W-1:0] v);
    logic [PROD_W-WAVE_W:0] upper;
    upper = v[PROD_W-1:WAVE_W-1];
    if ((&upper) || !(|upper))
      return v[WAVE_W-1:0];
    else if (v[PROD_W-1])
      return {1'b1, {(WAVE_W-1){1'b0}}};
    else
      return {1'b0, {(WAVE_W-1){1'b1}}};
  endfunction

  // Level is zero-extended so a full-scale level never reads as negative.
  always_comb begin
    wave_ext  = {{LVL_W{wave_in[WAVE_W-1]}}, wave_in};
    level_ext = {{WAVE_W{1'b0}}, level};
    prod      = wave_ext * level_ext;
    shifted   = prod >>> UNITY_SHIFT;
  end

  // Output register: captures the scaled sample and pulses valid once per tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wave_out   <= '0;
      wave_valid <= 1'b0;
    end else begin
      wave_valid <= tick;
      if (tick)
        wave_out <= sat_wave(shifted);
    end
  end

endmodule

// File: rtl/adsr_envelope_ctrl.sv
// adsr_envelope_ctrl: per-voice ADSR envelope FSM stepped once per sample
// tick, plus output scaling of the oscillator sample by the envelope level.
// Build option ENV_LEGATO_EN: when defined, a note change with the gate held
// does not retrigger the attack; only a gate rising edge does.
module adsr_envelope_ctrl
  import synth_env_pkg::*;
#(
  parameter int LVL_W       = synth_env_pkg::LVL_W,
  parameter int WAVE_W      = synth_env_pkg::WAVE_W,
  parameter int UNITY_SHIFT = synth_env_pkg::UNITY_SHIFT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     note_in,
  input  logic        [3:0]        note,
  input  logic        [LVL_W-1:0]  amplitude,
  input  logic        [LVL_W-1:0]  attack,
  input  logic        [LVL_W-1:0]  decay,
  input  logic        [LVL_W-1:0]  sustain,
  input  logic        [LVL_W-1:0]  rel,
  input  logic signed [WAVE_W-1:0] wave_in,
  output logic signed [WAVE_W-1:0] wave_out,
  output logic                     wave_valid,
  output logic        [LVL_W-1:0]  env_level,
  output logic        [2:0]        env_state,
  output logic                     env_active
);

  logic             gate_q;
  logic [3:0]       note_q;
  logic             trig_pending;
  logic             trig_evt;
  logic [LVL_W-1:0] level;
  logic [2:0]       state;
  logic [LVL_W-1:0] level_nxt;
  logic [2:0]       state_nxt;
  logic [LVL_W-1:0] sus_eff;
  logic [LVL_W:0]   att_sum;
  logic [LVL_W:0]   dec_diff;
  logic [LVL_W:0]   rel_diff;
  logic             go_rel;

`ifdef ENV_LEGATO_EN
  assign trig_evt = note_in & ~gate_q;
`else
  assign trig_evt = note_in & (~gate_q | (note != note_q));
`endif

  // One extra bit on each step catches overflow (attack) and underflow (decay/release).
  assign sus_eff  = (sustain < amplitude) ? sustain : amplitude;
  assign att_sum  = {1'b0, level} + {1'b0, attack};
  assign dec_diff = {1'b0, level} - {1'b0, decay};
  assign rel_diff = {1'b0, level} - {1'b0, rel};
  assign go_rel   = (!note_in && (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN))
                    || (state == ST_RELEASE);

  // Next-state/level for the coming tick: retrigger, then gate-off release, then normal step.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    if (trig_pending) begin
      state_nxt = ST_ATTACK;
    end else if (go_rel) begin
      if (rel == '0 || rel_diff[LVL_W] || rel_diff[LVL_W-1:0] == '0) begin
        level_nxt = '0;
        state_nxt = ST_IDLE;
      end else begin
        level_nxt = rel_diff[LVL_W-1:0];
        state_nxt = ST_RELEASE;
      end
    end else begin
      case (state)
        ST_ATTACK: begin
          if (attack == '0 || att_sum >= {1'b0, amplitude}) begin
            level_nxt = amplitude;
            state_nxt = ST_DECAY;
          end else begin
            level_nxt = att_sum[LVL_W-1:0];
          end
        end
        ST_DECAY: begin
          if (decay == '0 || dec_diff[LVL_W] || dec_diff[LVL_W-1:0] <= sus_eff) begin
            level_nxt = sus_eff;
            state_nxt = ST_SUSTAIN;
          end else begin
            level_nxt = dec_diff[LVL_W-1:0];
          end
        end
        ST_SUSTAIN: level_nxt = sus_eff;
        default: begin
          level_nxt = '0;
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Trigger detection every cycle; envelope state advances only on ticks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gate_q       <= 1'b0;
      note_q       <= '0;
      trig_pending <= 1'b0;
      level        <= '0;
      state        <= ST_IDLE;
    end else begin
      gate_q <= note_in;
      note_q <= note;
      if (trig_evt)
        trig_pending <= 1'b1;
      else if (tick)
        trig_pending <= 1'b0;
      if (tick) begin
        level <= level_nxt;
        state <= state_nxt;
      end
    end
  end

  assign env_level  = level;
  assign env_state  = state;
  assign env_active = (state != ST_IDLE);

  env_scaler #(
    .LVL_W       (LVL_W),
    .WAVE_W      (WAVE_W),
    .UNITY_SHIFT (UNITY_SHIFT)
  ) u_scaler (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .wave_in    (wave_in),
    .level      (level),
    .wave_out   (wave_out),
    .wave_valid (wave_valid)
  );

endmodule

// File: tb/tb_adsr_envelope_ctrl.sv
// Scoreboard bench for adsr_envelope_ctrl: each tick pushes the hand-computed
// envelope/sample expected after it; a monitor pops on wave_valid.
module tb_adsr_envelope_ctrl;
  import synth_env_pkg::*;

  localparam logic [30:0] L27   = 31'h0800_0000;
  localparam logic [30:0] L28   = 31'h1000_0000;
  localparam logic [30:0] L3_27 = 31'h1800_0000;
  localparam logic [30:0] L29   = 31'h2000_0000;
  localparam logic [30:0] L3_28 = 31'h3000_0000;
  localparam logic [30:0] L30   = 31'h4000_0000;
  localparam logic [30:0] LMAX  = 31'h7FFF_FFFF;
  localparam logic signed [31:0] WMAX = 32'h7FFF_FFFF;
  localparam logic signed [31:0] WMIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic note_in = 1'b0;
  logic [3:0] note = 4'd0;
  logic [30:0] amplitude = UNITY;
  logic [30:0] attack = '0;
  logic [30:0] decay = '0;
  logic [30:0] sustain = '0;
  logic [30:0] rel = '0;
  logic signed [31:0] wave_in = '0;
  logic signed [31:0] wave_out;
  logic wave_valid;
  logic [30:0] env_level;
  logic [2:0] env_state;
  logic env_active;

  typedef struct {
    int id;
    logic [30:0] lvl;
    logic [2:0] st;
    logic signed [31:0] wave;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;
  int step = 0;

  adsr_envelope_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .note_in    (note_in),
    .note       (note),
    .amplitude  (amplitude),
    .attack     (attack),
    .decay      (decay),
    .sustain    (sustain),
    .rel        (rel),
    .wave_in    (wave_in),
    .wave_out   (wave_out),
    .wave_valid (wave_valid),
    .env_level  (env_level),
    .env_state  (env_state),
    .env_active (env_active)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int id, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s t%0d: got %0d required %0d", name, id, act, req);
    end
  endtask

  task automatic do_tick(input logic [30:0] lvl, input logic [2:0] st, input logic signed [31:0] w);
    exp_t e;
    @(negedge clk);
    step++;
    e.id = step;
    e.lvl = lvl;
    e.st = st;
    e.wave = w;
    exp_q.push_back(e);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic check_reset_state(input int id);
    chk("rst_level", id, longint'(env_level), 0);
    chk("rst_state", id, longint'(env_state), longint'(ST_IDLE));
    chk("rst_active", id, longint'(env_active), 0);
    chk("rst_wave", id, longint'(wave_out), 0);
    chk("rst_valid", id, longint'(wave_valid), 0);
  endtask

  // Monitor: every valid pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (wave_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got valid with empty queue required none");
      end else begin
        mon_e = exp_q.pop_front();
        chk("level", mon_e.id, longint'(env_level), longint'(mon_e.lvl));
        chk("state", mon_e.id, longint'(env_state), longint'(mon_e.st));
        chk("active", mon_e.id, longint'(env_active), longint'(mon_e.st != ST_IDLE));
        chk("wave", mon_e.id, longint'(wave_out), longint'(mon_e.wave));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with ticks arriving: must be ignored.
    reset = 1'b0;
    tick = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state(0);
    tick = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // Attack ramp into decay(instant) then sustain.
    amplitude = L30; attack = L28; decay = '0; sustain = L29; rel = L28;
    wave_in = -1000;
    note = 4'd3;
    note_in = 1'b1;
    do_tick('0,    ST_ATTACK,  0);
    do_tick(L28,   ST_ATTACK,  0);
    do_tick(L29,   ST_ATTACK,  -250);
    do_tick(L3_28, ST_ATTACK,  -500);
    do_tick(L30,   ST_DECAY,   -750);
    do_tick(L29,   ST_SUSTAIN, -1000);
    do_tick(L29,   ST_SUSTAIN, -500);

    // Note change with gate held.
    note = 4'd5;
`ifdef ENV_LEGATO_EN
    do_tick(L29,   ST_SUSTAIN, -500);
    do_tick(L29,   ST_SUSTAIN, -500);
    do_tick(L29,   ST_SUSTAIN, -500);
    do_tick(L29,   ST_SUSTAIN, -500);
`else
    do_tick(L29,   ST_ATTACK,  -500);
    do_tick(L3_28, ST_ATTACK,  -500);
    do_tick(L30,   ST_DECAY,   -750);
    do_tick(L29,   ST_SUSTAIN, -1000);
`endif

    // Sustain tracks live params and is clamped to amplitude.
    sustain = L30; amplitude = L30;
    do_tick(L30,   ST_SUSTAIN, -500);
    amplitude = L29;
    do_tick(L29,   ST_SUSTAIN, -1000);

    // Release to idle.
    note_in = 1'b0;
    do_tick(L28,   ST_RELEASE, -500);
    do_tick('0,    ST_IDLE,    -250);

    // Build some level, then release, then short tap from a non-zero level.
    amplitude = L30; sustain = L29; attack = L28; rel = L27;
    note_in = 1'b1;
    do_tick('0,    ST_ATTACK,  0);
    do_tick(L28,   ST_ATTACK,  0);
    do_tick(L29,   ST_ATTACK,  -250);
    note_in = 1'b0;
    do_tick(L3_27, ST_RELEASE, -500);
    note_in = 1'b1;
    @(negedge clk);
    note_in = 1'b0;
    do_tick(L3_27, ST_ATTACK,  -375);
    do_tick(L28,   ST_RELEASE, -375);
    rel = '0;
    do_tick('0,    ST_IDLE,    -250);

    // Full-scale level with instant attack: positive and negative saturation.
    amplitude = LMAX; attack = '0; decay = '0; sustain = LMAX;
    wave_in = WMAX;
    note_in = 1'b1;
    do_tick('0,    ST_ATTACK,  0);
    do_tick(LMAX,  ST_DECAY,   0);
    do_tick(LMAX,  ST_SUSTAIN, WMAX);
    wave_in = WMIN;
    do_tick(LMAX,  ST_SUSTAIN, WMIN);

    // Decay stepping down to sustain.
    wave_in = 0; amplitude = L30; sustain = L28; decay = L28;
    do_tick(L28,   ST_SUSTAIN, 0);
    note_in = 1'b0;
    @(negedge clk);
    note_in = 1'b1;
    do_tick(L28,   ST_ATTACK,  0);
    do_tick(L30,   ST_DECAY,   0);
    do_tick(L3_28, ST_DECAY,   0);
    do_tick(L29,   ST_DECAY,   0);
    do_tick(L28,   ST_SUSTAIN, 0);

    // Reset in the middle of an attack.
    note_in = 1'b0;
    @(negedge clk);
    note_in = 1'b1;
    attack = L28;
    do_tick(L28,   ST_ATTACK,  0);
    wave_in = -1000;
    do_tick(L29,   ST_ATTACK,  -250);
    reset = 1'b0;
    tick = 1'b1;
    @(negedge clk);
    check_reset_state(99);
    tick = 1'b0;
    reset = 1'b1;
    note_in = 1'b0;
    repeat (4) @(negedge clk);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
